aes_sca_host: RTL

AES_SCA_HOST -- requirements
Module: aes_sca_host

---
 rtl/aes_sca_host.sv | 112 +++++++++++
 1 files changed

// File: rtl/aes_sca_host.sv
// aes_sca_host: drives key/plaintext bytes into an AES chip, starts it, captures its 16 output bytes
module aes_sca_host #(
  parameter int FIRST_BYTE_DELAY = 33,
  parameter int DRAIN_TIMEOUT = 8
) (
  input  logic         i_clock,
  input  logic         i_reset,
  input  logic         i_go,
  input  logic [127:0] i_key,
  input  logic [127:0] i_plaintext,
  input  logic [7:0]   i_dut_byte_in,
  input  logic         i_dut_active,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_error,
  output logic [127:0] o_result,
  output logic [7:0]   o_dut_byte,
  output logic         o_dut_key_strobe,
  output logic         o_dut_pt_strobe,
  output logic         o_dut_start
);
  localparam int DW = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
  typedef enum logic [3:0] {
    S_IDLE, S_LOAD_KEY, S_LOAD_PT, S_START, S_CHECK, S_WAIT_CAP, S_CAPTURE, S_DRAIN, S_DONE
  } state_t;
  state_t r_state, w_state;
  logic [1:0] r_ph, w_ph;
  logic [3:0] r_idx, w_idx;
  logic [5:0] r_cyc;
  logic [DW-1:0] r_drain;
  logic [127:0] r_key, r_pt, w_key, w_pt, w_sel, r_result;
  logic [7:0] w_byte, r_byte;
  logic w_to, w_load, r_busy, r_done, r_error, r_ks, r_ps, r_start;
  assign w_to = r_drain == DW'(DRAIN_TIMEOUT - 1);
  assign w_load = (w_state == S_LOAD_KEY) || (w_state == S_LOAD_PT);
  assign w_sel = (w_state == S_LOAD_KEY) ? w_key : w_pt;
  assign w_byte = 8'(w_sel >> {~w_idx, 3'b000});
  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_error = r_error;
  assign o_result = r_result;
  assign o_dut_byte = r_byte;
  assign o_dut_key_strobe = r_ks;
  assign o_dut_pt_strobe = r_ps;
  assign o_dut_start = r_start;
  // next state, byte phase and byte index; outputs are registered from these
  always_comb begin
    w_state = r_state;
    w_ph = r_ph;
    w_idx = r_idx;
    w_key = (r_state == S_IDLE && i_go) ? i_key : r_key;
    w_pt = (r_state == S_IDLE && i_go) ? i_plaintext : r_pt;
    case (r_state)
      S_IDLE: begin
        w_state = i_go ? S_LOAD_KEY : S_IDLE;
        w_ph = 2'd0;
        w_idx = 4'd0;
      end
      S_LOAD_KEY, S_LOAD_PT: begin
        w_ph = (r_ph == 2'd2) ? 2'd0 : r_ph + 2'd1;
        w_idx = (r_ph == 2'd2) ? r_idx + 4'd1 : r_idx;
        if (r_ph == 2'd2 && r_idx == 4'hF) w_state = (r_state == S_LOAD_KEY) ? S_LOAD_PT : S_START;
      end
      S_START: w_state = S_CHECK;
      S_CHECK: w_state = i_dut_active ? S_WAIT_CAP : S_DONE;
      S_WAIT_CAP: w_state = (r_cyc == 6'(FIRST_BYTE_DELAY - 1)) ? S_CAPTURE : S_WAIT_CAP;
      S_CAPTURE: begin
        w_idx = r_idx + 4'd1;
        w_state = (r_idx == 4'hF) ? S_DRAIN : S_CAPTURE;
      end
      S_DRAIN: w_state = (!i_dut_active || w_to) ? S_DONE : S_DRAIN;
      default: w_state = S_IDLE;
    endcase
  end
  // state, counters, latched operands and registered outputs
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_ph <= '0;
      r_idx <= '0;
      r_cyc <= '0;
      r_drain <= '0;
      r_key <= '0;
      r_pt <= '0;
      r_result <= '0;
      r_byte <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_error <= 1'b0;
      r_ks <= 1'b0;
      r_ps <= 1'b0;
      r_start <= 1'b0;
    end else begin
      r_state <= w_state;
      r_ph <= w_ph;
      r_idx <= w_idx;
      r_key <= w_key;
      r_pt <= w_pt;
      r_cyc <= (w_state == S_START) ? '0 : r_cyc + 6'd1;
      r_drain <= (r_state == S_DRAIN) ? r_drain + DW'(1) : '0;
      if (r_state == S_IDLE && i_go) r_error <= 1'b0;
      else if ((r_state == S_CHECK && !i_dut_active) || (r_state == S_DRAIN && i_dut_active && w_to)) r_error <= 1'b1;
      if (r_state == S_CAPTURE) r_result <= {r_result[119:0], i_dut_byte_in};
      r_byte <= w_load ? w_byte : 8'h00;
      r_busy <= w_state != S_IDLE;
      r_done <= w_state == S_DONE;
      r_ks <= (w_state == S_LOAD_KEY) && (w_ph == 2'd1);
      r_ps <= (w_state == S_LOAD_PT) && (w_ph == 2'd1);
      r_start <= w_state == S_START;
    end
  end
endmodule
